// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, ALUOp codes,
// mux selects, the sequencer state set and the bundled control-word layout.
package multicycle_control_fsm_pkg;

  localparam int OPC_BITS   = 4;
  localparam int STATE_BITS = 4;

  localparam logic [OPC_BITS-1:0] OPC_R0    = 4'b0000;
  localparam logic [OPC_BITS-1:0] OPC_R1    = 4'b0001;
  localparam logic [OPC_BITS-1:0] OPC_SHIFT = 4'b0010;
  localparam logic [OPC_BITS-1:0] OPC_LW    = 4'b0100;
  localparam logic [OPC_BITS-1:0] OPC_SW    = 4'b0101;
  localparam logic [OPC_BITS-1:0] OPC_BEQ   = 4'b0110;
  localparam logic [OPC_BITS-1:0] OPC_J     = 4'b0111;
  localparam logic [OPC_BITS-1:0] OPC_ADDI  = 4'b1001;
  localparam logic [OPC_BITS-1:0] OPC_SUBI  = 4'b1010;
  localparam logic [OPC_BITS-1:0] OPC_SLTI  = 4'b1011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] ALUSRCB_RT     = 2'b00;
  localparam logic [1:0] ALUSRCB_CONST2 = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // Dispatch target out of DECODE; anything not listed traps to ILLEGAL.
  function automatic state_t decode_next(input logic [OPC_BITS-1:0] opc);
    state_t nxt;
    case (opc)
      OPC_LW, OPC_SW:                        nxt = S_MEM_ADDR;
      OPC_R0, OPC_R1:                        nxt = S_EXEC_R;
      OPC_SHIFT, OPC_ADDI, OPC_SUBI, OPC_SLTI: nxt = S_EXEC_I;
      OPC_BEQ:                               nxt = S_BRANCH;
      OPC_J:                                 nxt = S_JUMP;
      default:                               nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_control_out_decode.sv
// Control-out decode: registered sequencer state -> datapath control word.
// Only FETCH's write enables (mem_ready) and PCWriteCond (zero) look past the state.
module multicycle_control_fsm_control_out_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUSRCB_CONST2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUSRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_RT;
        ctrl.alu_op    = ALUOP_R;
      end
      S_WB_R: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_I;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = zero;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer of the 16-bit multicycle CPU: steps each instruction
// through fetch/decode/execute/memory/writeback and stalls on mem_ready.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPC_W   = OPC_BITS,
  parameter int STATE_W = STATE_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  input  logic               zero,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state;
  ctrl_t  ctrl;

  // Outputs are decoded from this register, so an async reset drops any
  // pending write strobe in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next(opcode);
        S_EXEC_R:   state <= S_WB_R;
        S_WB_R:     state <= S_FETCH;
        S_EXEC_I:   state <= S_WB_I;
        S_WB_I:     state <= S_FETCH;
        S_MEM_ADDR: state <= (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        S_ILLEGAL:  state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  multicycle_control_fsm_control_out_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign illegal_op  = ctrl.illegal_op;
  assign state_dbg   = state;

endmodule
